// File: rtl/mul_div_unit_pkg.sv
// Shared opcode definitions for the multiply/divide unit.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package mul_div_unit_pkg;

    localparam int MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the E stage and the multiply/divide unit.
// Latency: none, wiring only.
// Backpressure: busy tells the hazard unit to hold later HI/LO users.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    import mul_div_unit_pkg::*;

    logic                 start;
    logic [MD_OP_W-1:0]   md_op;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 flush;
    logic                 busy;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [WIDTH-1:0]     md_result;

    modport master (
        output start, md_op, in_a, in_b, flush,
        input  busy, hi, lo, md_result
    );

    modport slave (
        input  start, md_op, in_a, in_b, flush,
        output busy, hi, lo, md_result
    );

endinterface

// File: rtl/mul_div_unit_md_latency_ctr.sv
// Down-counter that models the busy window of a multi-cycle op.
// Latency: busy rises the cycle after load; done marks the edge count reaches 0.
// Backpressure: load is only honoured when idle; clear aborts immediately.
module md_latency_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic             busy,
    output logic             done
);

    logic [CNT_W-1:0] count;

    assign busy = (count != '0);
    assign done = (count == CNT_W'(1));

    // Load on accepted op, count down while busy, clear on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load && !busy) begin
            count <= load_val;
        end else if (busy) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle mult/div with architectural HI/LO for the E stage.
// Latency: MUL_CYCLES / DIV_CYCLES from start edge to HI/LO update; MTHI/MTLO 1 edge.
// Backpressure: busy high while an op is in flight; start during busy is ignored.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  md
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [WIDTH-1:0]   hi_r, lo_r;
    logic [WIDTH-1:0]   hi_n, lo_n;
    logic               commit_ok;
    logic               busy, done;
    logic               accept, is_mul, is_div;
    logic [WIDTH-1:0]   calc_hi, calc_lo;
    logic               calc_ok;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [CNT_W-1:0]   load_val;

    assign accept = md.start && !busy && !md.flush;
    assign is_mul = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU);
    assign is_div = (md.md_op == MD_DIV)  || (md.md_op == MD_DIVU);

    assign prod_s = $signed({{WIDTH{md.in_a[WIDTH-1]}}, md.in_a}) *
                    $signed({{WIDTH{md.in_b[WIDTH-1]}}, md.in_b});
    assign prod_u = {{WIDTH{1'b0}}, md.in_a} * {{WIDTH{1'b0}}, md.in_b};

    // Result that will be committed at the end of the busy window.
    always_comb begin
        calc_hi = '0;
        calc_lo = '0;
        calc_ok = 1'b0;
        case (md.md_op)
            MD_MULT: begin
                {calc_hi, calc_lo} = prod_s;
                calc_ok = 1'b1;
            end
            MD_MULTU: begin
                {calc_hi, calc_lo} = prod_u;
                calc_ok = 1'b1;
            end
            MD_DIV: begin
                if (md.in_b != '0) begin
                    calc_ok = 1'b1;
                    // Most-negative / -1 wraps: quotient is the dividend, remainder 0.
                    if (md.in_a == {1'b1, {(WIDTH-1){1'b0}}} && md.in_b == {WIDTH{1'b1}}) begin
                        calc_lo = md.in_a;
                        calc_hi = '0;
                    end else begin
                        calc_lo = $signed(md.in_a) / $signed(md.in_b);
                        calc_hi = $signed(md.in_a) % $signed(md.in_b);
                    end
                end
            end
            MD_DIVU: begin
                if (md.in_b != '0) begin
                    calc_ok = 1'b1;
                    calc_lo = md.in_a / md.in_b;
                    calc_hi = md.in_a % md.in_b;
                end
            end
            default: ;
        endcase
    end

    assign load_val = is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);

    md_latency_ctr #(
        .CNT_W    (CNT_W)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && (is_mul || is_div)),
        .load_val (load_val),
        .clear    (md.flush),
        .busy     (busy),
        .done     (done)
    );

    // Capture pending result at start, commit it (or a move) into HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r      <= '0;
            lo_r      <= '0;
            hi_n      <= '0;
            lo_n      <= '0;
            commit_ok <= 1'b0;
        end else if (md.flush) begin
            commit_ok <= 1'b0;
        end else begin
            if (accept && (is_mul || is_div)) begin
                hi_n      <= calc_hi;
                lo_n      <= calc_lo;
                commit_ok <= calc_ok;
            end
            if (done && commit_ok) begin
                hi_r      <= hi_n;
                lo_r      <= lo_n;
                commit_ok <= 1'b0;
            end
            if (accept && md.md_op == MD_MTHI) hi_r <= md.in_a;
            if (accept && md.md_op == MD_MTLO) lo_r <= md.in_a;
        end
    end

    assign md.busy      = busy;
    assign md.hi        = hi_r;
    assign md.lo        = lo_r;
    assign md.md_result = (md.md_op == MD_MFHI) ? hi_r :
                          (md.md_op == MD_MFLO) ? lo_r : '0;

endmodule
